// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// mmio_timer : memory-mapped countdown timer (CTRL/PRESET/COUNT) raising a
//              level interrupt on expiry. MMIO_TIMER_AUTORELOAD_EN adds reload.
// Revision   : 1.0
// ============================================================================
module mmio_timer #(
    parameter int PRESET_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_CNT    = 2'd2;
    localparam logic [1:0] S_INT    = 2'd3;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                en_q, en_d;
    logic                im_q, im_d;
    logic                pend_q, pend_d;
    logic [PRESET_W-1:0] preset_q, preset_d;
    logic [PRESET_W-1:0] count_q, count_d;

    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_en_eff;
    logic        w_reload;
    logic [1:0]  w_mode;
    logic [31:0] w_preset_rd;
    logic [31:0] w_count_rd;
    logic        w_unused;

    assign w_wr_ctrl   = sel & we & (addr[3:2] == A_CTRL);
    assign w_wr_preset = sel & we & (addr[3:2] == A_PRESET);
    // FSM decisions see EN as it will be after this cycle's store.
    assign w_en_eff    = w_wr_ctrl ? wd[0] : en_q;
    assign w_unused    = ^{addr[31:4], addr[1:0], wd};

`ifdef MMIO_TIMER_AUTORELOAD_EN
    logic [1:0] mode_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= 2'b00;
        end else if (w_wr_ctrl) begin
            mode_q <= wd[2:1];
        end
    end

    assign w_mode = mode_q;
`else
    assign w_mode = 2'b00;
`endif

    assign w_reload = (w_mode == 2'b01);

    generate
        if (PRESET_W < 32) begin : g_pad
            assign w_preset_rd = {{(32-PRESET_W){1'b0}}, preset_q};
            assign w_count_rd  = {{(32-PRESET_W){1'b0}}, count_q};
        end else begin : g_full
            assign w_preset_rd = preset_q[31:0];
            assign w_count_rd  = count_q[31:0];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        im_d     = im_q;
        pend_d   = pend_q;
        preset_d = preset_q;
        count_d  = count_q;

        if (w_wr_preset) begin
            preset_d = wd[PRESET_W-1:0];
        end
        if (w_wr_ctrl || w_wr_preset) begin
            pend_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_en_eff) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!w_en_eff) begin
                    state_d = S_IDLE;
                end else if (count_q <= PRESET_W'(1)) begin
                    count_d = '0;
                    state_d = S_INT;
                end else begin
                    count_d = count_q - PRESET_W'(1);
                end
            end
            default: begin
                // Setting PEND here overrides the software clear above.
                pend_d = 1'b1;
                if (w_reload) begin
                    state_d = S_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase

        // A store to CTRL beats the FSM's own EN clear.
        if (w_wr_ctrl) begin
            en_d = wd[0];
            im_d = wd[3];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            im_q     <= 1'b0;
            pend_q   <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            im_q     <= im_d;
            pend_q   <= pend_d;
            preset_q <= preset_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        rd = 32'd0;
        if (sel) begin
            case (addr[3:2])
                A_CTRL:   rd = {28'd0, im_q, w_mode, en_q};
                A_PRESET: rd = w_preset_rd;
                A_COUNT:  rd = w_count_rd;
                default:  rd = 32'd0;
            endcase
        end
    end

    assign irq = pend_q & im_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer.sv
`default_nettype none
// ============================================================================
// tb_mmio_timer : vector table, directed corner sequences and randomized
//                 traffic against a behavioural model of the timer.
// Revision      : 1.0
// ============================================================================
module tb_mmio_timer;

`ifdef MMIO_TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          s;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] erd;
        bit          eirq;
    } vec_t;

    vec_t vecs [19];

    // Behavioural model state
    bit          m_en, m_im, m_pend;
    bit [1:0]    m_mode;
    logic [31:0] m_preset, m_count;
    int          m_phase;

    mmio_timer #(.PRESET_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d);
        sel = s; we = w; addr = a; wd = d;
    endtask

    task automatic put(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d);
        drive(s, w, a, d);
        @(posedge clk); #1;
    endtask

    task automatic cyc(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input string name, input logic [31:0] erd, input bit eirq);
        drive(s, w, a, d);
        @(negedge clk);
        chk({name, " rd"}, rd, erd);
        chk({name, " irq"}, {31'd0, irq}, {31'd0, eirq});
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] exp_autoreload_count(input int k);
        int p;
        logic [31:0] v;
        p = (k - 1) % 5;
        v = (p < 3) ? 32'(3 - p) : 32'd0;
        if (!AR && k > 5) v = 32'd0;
        return v;
    endfunction

    function automatic void model_reset();
        m_en = 0; m_im = 0; m_pend = 0; m_mode = 2'b00;
        m_preset = 0; m_count = 0; m_phase = PH_IDLE;
    endfunction

    function automatic logic [31:0] model_rd(input bit s, input logic [31:0] a);
        if (!s) return 32'd0;
        case (a[3:2])
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_step(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d);
        bit wc, wp, en_after_store, next_en, next_pend;
        logic [31:0] next_count;
        int next_phase;
        wc = s && w && (a[3:2] == 2'd0);
        wp = s && w && (a[3:2] == 2'd1);
        en_after_store = wc ? d[0] : m_en;
        next_en = m_en;
        next_pend = (wc || wp) ? 1'b0 : m_pend;
        next_count = m_count;
        next_phase = m_phase;
        if (m_phase == PH_IDLE) begin
            if (en_after_store) next_phase = PH_LOAD;
        end else if (m_phase == PH_LOAD) begin
            next_count = m_preset;
            next_phase = PH_CNT;
        end else if (m_phase == PH_CNT) begin
            if (!en_after_store) next_phase = PH_IDLE;
            else if (m_count < 2) begin next_count = 0; next_phase = PH_INT; end
            else next_count = m_count - 1;
        end else begin
            next_pend = 1'b1;
            if (AR && m_mode == 2'b01) next_phase = PH_LOAD;
            else begin next_en = 1'b0; next_phase = PH_IDLE; end
        end
        if (wc) begin
            next_en = d[0];
            m_im = d[3];
            m_mode = AR ? d[2:1] : 2'b00;
        end
        if (wp) m_preset = d;
        m_en = next_en; m_pend = next_pend; m_count = next_count; m_phase = next_phase;
    endfunction

    initial begin
        bit found;
        bit rs, rw;
        logic [31:0] ra, rdat;

        vecs[0]  = '{1, 0, 32'h0, 32'h0, 32'h0, 0};
        vecs[1]  = '{1, 0, 32'h4, 32'h0, 32'h0, 0};
        vecs[2]  = '{1, 0, 32'h8, 32'h0, 32'h0, 0};
        vecs[3]  = '{1, 0, 32'hC, 32'h0, 32'h0, 0};
        vecs[4]  = '{0, 0, 32'h4, 32'h0, 32'h0, 0};
        vecs[5]  = '{1, 1, 32'h4, 32'h5, 32'h0, 0};
        vecs[6]  = '{1, 0, 32'h4, 32'h0, 32'h5, 0};
        vecs[7]  = '{1, 1, 32'h0, 32'h9, 32'h0, 0};
        vecs[8]  = '{1, 0, 32'h8, 32'h0, 32'h0, 0};
        vecs[9]  = '{1, 0, 32'h8, 32'h0, 32'h5, 0};
        vecs[10] = '{1, 0, 32'h8, 32'h0, 32'h4, 0};
        vecs[11] = '{1, 0, 32'h8, 32'h0, 32'h3, 0};
        vecs[12] = '{1, 0, 32'h8, 32'h0, 32'h2, 0};
        vecs[13] = '{1, 0, 32'h8, 32'h0, 32'h1, 0};
        vecs[14] = '{1, 0, 32'h8, 32'h0, 32'h0, 0};
        vecs[15] = '{1, 0, 32'h0, 32'h0, 32'h8, 1};
        vecs[16] = '{1, 1, 32'h0, 32'h8, 32'h8, 1};
        vecs[17] = '{1, 0, 32'h8, 32'h0, 32'h0, 0};
        vecs[18] = '{1, 0, 32'h0, 32'h0, 32'h8, 0};

        do_reset();

        // One-shot walk-through and interrupt clear
        for (int i = 0; i < 19; i++) begin
            cyc(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d, $sformatf("vec%0d", i),
                vecs[i].erd, vecs[i].eirq);
        end

        // Auto-reload (single expiry when the feature is absent)
        put(1, 1, 32'h4, 32'h3);
        put(1, 1, 32'h0, 32'hB);
        cyc(1, 0, 32'h0, 0, "ar ctrl", AR ? 32'hB : 32'h9, 0);
        for (int k = 1; k <= 10; k++) begin
            cyc(1, 0, 32'h8, 0, $sformatf("ar count e%0d", k), exp_autoreload_count(k), k >= 5);
        end
        cyc(1, 1, 32'h4, 32'h3, "ar preset wr", 32'h3, 1);
        cyc(1, 1, 32'h0, 32'h8, "ar stop", AR ? 32'hB : 32'h8, 0);
        cyc(1, 0, 32'h0, 0, "ar ctrl after", 32'h8, 0);

        // Freeze on EN clear, reload on re-enable
        put(1, 1, 32'h4, 32'd10);
        put(1, 1, 32'h0, 32'h9);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(1, 0, 32'h8, 0);
            @(negedge clk);
            if (rd == 32'd6) begin
                found = 1;
                drive(1, 1, 32'h0, 32'h8);
            end
            @(posedge clk); #1;
        end
        chk("freeze reached count 6", {31'd0, found}, 32'd1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 32'h8, 0, "freeze hold", 32'd6, 0);
        cyc(1, 1, 32'h0, 32'h9, "reenable", 32'h8, 0);
        cyc(1, 0, 32'h8, 0, "reenable load", 32'd6, 0);
        cyc(1, 0, 32'h8, 0, "reenable reload", 32'd10, 0);
        cyc(1, 0, 32'h8, 0, "reenable dec", 32'd9, 0);
        put(1, 1, 32'h0, 32'h0);

        // Asynchronous reset mid-count
        put(1, 1, 32'h4, 32'd10);
        put(1, 1, 32'h0, 32'h9);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(1, 0, 32'h8, 0);
            @(negedge clk);
            if (rd == 32'd4) found = 1;
            else begin @(posedge clk); #1; end
        end
        chk("reset reached count 4", {31'd0, found}, 32'd1);
        reset = 1'b0;
        #1 chk("rst count", rd, 32'd0);
        addr = 32'h0;
        #1 chk("rst ctrl", rd, 32'd0);
        addr = 32'h4;
        #1 chk("rst preset", rd, 32'd0);
        chk("rst irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) cyc(1, 0, 32'h8, 0, "post reset idle", 32'd0, 0);

        // PRESET=0 expiry with a CTRL store landing on the PEND-set edge
        put(1, 1, 32'h4, 32'h0);
        put(1, 1, 32'h0, 32'h1);
        cyc(1, 0, 32'h8, 0, "p0 load", 32'd0, 0);
        cyc(1, 0, 32'h8, 0, "p0 cnt", 32'd0, 0);
        cyc(1, 1, 32'h0, 32'h8, "p0 int wr", 32'h1, 0);
        cyc(1, 0, 32'h0, 0, "p0 set wins", 32'h8, 1);
        cyc(1, 1, 32'h0, 32'h8, "p0 clear", 32'h8, 1);
        cyc(1, 0, 32'h0, 0, "p0 cleared", 32'h8, 0);

        // Randomized traffic against the model
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom % 4) != 0;
            rw = ($urandom % 6) == 0;
            ra = $urandom;
            rdat = $urandom;
            if (ra[3:2] == 2'b01) rdat = $urandom_range(0, 6);
            drive(rs, rw, ra, rdat);
            @(negedge clk);
            chk("rand rd", rd, model_rd(rs, ra));
            chk("rand irq", {31'd0, irq}, {31'd0, m_pend & m_im});
            @(posedge clk);
            model_step(rs, rw, ra, rdat);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped countdown timer that acts as a responder on the single-cycle CPU's data-memory bus. It shares the address, write-enable and write-data bus that the CPU already drives toward data memory, and returns read data on the same cycle. On expiry it raises a level interrupt for the CP0 exception path. The system address decoder drives `sel` when the address falls inside this block's 12-byte window.

## Interface
Parameters:
- `PRESET_W`, 32: width of the PRESET and COUNT registers; upper bits read 0 if less than 32.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately.
- `sel`  in  1  block selected by the system address decoder.
- `we`  in  1  CPU store strobe (word store).
- `addr`  in  32  byte address; only `addr[3:2]` is decoded.
- `wd`  in  32  store data.
- `rd`  out  32  combinational load data.
- `irq`  out  1  interrupt request to CP0; level, active-high.

## Operation
Register map, indexed by `addr[3:2]`:
- `00` CTRL (R/W):
  - bit0 EN
  - bits2:1 MODE: 00 = one-shot, 01 = auto-reload; 1x behaves as 00
  - bit3 IM (interrupt mask enable)
  - bits31:4 read 0
- `01` PRESET (R/W).
- `10` COUNT (read-only; writes are ignored).
- `11` reads 0; writes are ignored.
- Reads: `rd` = selected register when `sel`=1, otherwise 0. Loads have no side effects.
- Writes occur when `sel`&`we` at the clock edge.
- Any write to CTRL or PRESET clears PEND.

State machine (IDLE, LOAD, CNT, INT):
- IDLE: if EN → LOAD.
- LOAD: COUNT ← PRESET; → CNT.
- CNT:
  - if !EN → IDLE, COUNT held.
  - else if COUNT ≤ 1 → COUNT ← 0; → INT.
  - else COUNT ← COUNT−1.
- INT: PEND ← 1.
  - MODE=01: → LOAD.
  - otherwise: EN ← 0; → IDLE.
- `irq` = PEND & IM.

Boundary rules:
- PRESET = 0 behaves identically to PRESET = 1.
- A PRESET write during CNT takes effect at the next LOAD only.
- A CTRL write in the same cycle the FSM clears EN in INT: the CPU-written value wins.
- A CTRL/PRESET write in the same cycle PEND is being set: the set wins, so the event is not lost.
- Clearing EN mid-count freezes COUNT. Re-enabling reloads from PRESET via LOAD.
- Asserting `reset` mid-count aborts immediately. There is no partial state.

## Timing
- Reset values:
  - CTRL, PRESET, COUNT, PEND = 0; state IDLE.
  - `irq` = 0.
  - `rd` = 0.
- Write-to-register latency: 1 edge. `rd` reflects the new value on the following cycle.
- One-shot, PRESET = N ≥ 1, EN written at edge 0:
  - edge 1: COUNT = N.
  - edge N+1: COUNT = 0, state INT.
  - edge N+2: PEND = 1, `irq` rises if IM = 1.
- Auto-reload: INT recurs every N+2 cycles. PEND stays set until software clears it.
- `irq` is registered-derived with no combinational path from `wd`.

## Configuration
- `MMIO_TIMER_AUTORELOAD_EN` defined:
  - MODE = 01 reloads as described.
  - MODE bits are stored and read back.
- Not defined:
  - MODE bits are not stored and read back as 00.
  - INT always clears EN and returns to IDLE (one-shot only).

## Test plan
- Reset, then read all three offsets → each returns 0; `irq` = 0.
- Write PRESET = 5, then CTRL = 0x9 (EN, IM, one-shot) → COUNT reads 5,4,3,2,1,0 on successive cycles; `irq` rises 7 edges after the CTRL write edge; CTRL reads 0x8.
- With `irq` high, write CTRL = 0x8 → `irq` falls on the next cycle; COUNT stays 0.
- With the macro defined, PRESET = 3 and CTRL = 0xB → INT is entered every 5 cycles; `irq` stays high across reloads until a PRESET write. Without the macro, CTRL reads 0x9 and only one expiry occurs.
- PRESET = 10, enable, then write CTRL = 0x8 at COUNT = 6 → COUNT holds 6. Re-enabling with CTRL = 0x9 → COUNT reloads to 10.
- Pulse `reset` low mid-count at COUNT = 4 → all registers read 0 in the same cycle; `irq` = 0; no expiry follows.
